// File: rtl/fifo_lane_pkg.sv
// rtl/fifo_lane_pkg.sv - shared lane FIFO defaults and pointer-width helper
package fifo_lane_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int AF_LEVEL_DEF   = 3;
  localparam int AE_LEVEL_DEF   = 1;

  // Pointer width for a power-of-two depth; the occupancy counter is one bit wider.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - per-lane synchronous FIFO with registered read port and sticky error
module fifo_lane
  import fifo_lane_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_LEVEL   = AF_LEVEL_DEF,
  parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push_ok, pop_ok;

  // A pop frees the slot a same-cycle push needs, so full+push+pop is legal.
  assign push_ok = push && (!full_q || pop);
  assign pop_ok  = pop && !empty_q;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = pop_ok;
    err_d    = err_q || (push && !push_ok) || (pop && !pop_ok);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = rd_data;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags come from the next occupancy so they settle with the edge.
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_W'(AF_LEVEL));
    ae_d    = (count_d <= CNT_W'(AE_LEVEL));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign error        = err_q;

endmodule

// File: tb/tb_fifo_lane.sv
// tb/tb_fifo_lane.sv - vector table, corner sequences and queue-model random test for fifo_lane
module tb_fifo_lane;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [DW-1:0] data_in;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty, almost_full, almost_empty, error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a plain queue of words plus the last popped word and sticky error.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_err;

  typedef struct {
    bit       push;
    bit       pop;
    bit [7:0] din;
    bit [7:0] dout;
    bit       valid;
    bit       full;
    bit       empty;
    bit       af;
    bit       ae;
    bit       err;
  } vec_t;

  vec_t vt[11];

  fifo_lane #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_step(input bit p, input bit q, input logic [DW-1:0] d);
    bool_pop: begin
      if (q) begin
        if (mq.size() > 0) begin
          m_data  = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_err   = 1'b1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_err = 1'b1;
    end
  endfunction

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    if (m_valid) chk({tag, ".data"}, 32'(data_out), 32'(m_data));
    chk({tag, ".full"},  32'(full),         32'(sz == DEPTH));
    chk({tag, ".empty"}, 32'(empty),        32'(sz == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(sz >= AF));
    chk({tag, ".ae"},    32'(almost_empty), 32'(sz <= AE));
    chk({tag, ".err"},   32'(error),        32'(m_err));
  endtask

  task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input string tag);
    push    = p;
    pop     = q;
    data_in = d;
    model_step(p, q, d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".data"},  32'(data_out),     32'h0);
    chk({tag, ".valid"}, 32'(valid_out),    32'h0);
    chk({tag, ".full"},  32'(full),         32'h0);
    chk({tag, ".empty"}, 32'(empty),        32'h1);
    chk({tag, ".af"},    32'(almost_full),  32'h0);
    chk({tag, ".ae"},    32'(almost_empty), 32'h1);
    chk({tag, ".err"},   32'(error),        32'h0);
  endtask

  task automatic do_reset();
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    reset_L = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_L = 1'b1;
  endtask

  initial begin
    //            push pop din    dout   v  f  e  af ae err
    vt[0]  = '{1, 0, 8'hA1, 8'h00, 0, 0, 0, 0, 1, 0};
    vt[1]  = '{1, 0, 8'hB2, 8'h00, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 8'hC3, 8'h00, 0, 0, 0, 1, 0, 0};
    vt[3]  = '{1, 0, 8'hD4, 8'h00, 0, 1, 0, 1, 0, 0};
    vt[4]  = '{1, 0, 8'hEE, 8'h00, 0, 1, 0, 1, 0, 1};
    vt[5]  = '{0, 1, 8'h00, 8'hA1, 1, 0, 0, 1, 0, 1};
    vt[6]  = '{0, 1, 8'h00, 8'hB2, 1, 0, 0, 0, 0, 1};
    vt[7]  = '{0, 1, 8'h00, 8'hC3, 1, 0, 0, 0, 1, 1};
    vt[8]  = '{0, 1, 8'h00, 8'hD4, 1, 0, 1, 0, 1, 1};
    vt[9]  = '{0, 0, 8'h00, 8'hD4, 0, 0, 1, 0, 1, 1};
    vt[10] = '{0, 1, 8'h00, 8'hD4, 0, 0, 1, 0, 1, 1};

    reset_L = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    #2;
    do_reset();

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vt[i].push, vt[i].pop, vt[i].din, {t, ".model"});
      chk({t, ".data"},  32'(data_out),     32'(vt[i].dout));
      chk({t, ".valid"}, 32'(valid_out),    32'(vt[i].valid));
      chk({t, ".full"},  32'(full),         32'(vt[i].full));
      chk({t, ".empty"}, 32'(empty),        32'(vt[i].empty));
      chk({t, ".af"},    32'(almost_full),  32'(vt[i].af));
      chk({t, ".ae"},    32'(almost_empty), 32'(vt[i].ae));
      chk({t, ".err"},   32'(error),        32'(vt[i].err));
    end

    // Two resident entries, eight cycles of simultaneous push+pop.
    do_reset();
    step(1, 0, 8'h0E, "pp.fill0");
    step(1, 0, 8'h0F, "pp.fill1");
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 8'(8'h10 + i), "pp.stream");
      chk("pp.err", 32'(error), 32'h0);
      chk("pp.data", 32'(data_out), (i < 2) ? 32'(8'h0E + i) : 32'(8'h10 + i - 2));
    end
    step(0, 1, 8'h00, "pp.drain0");
    chk("pp.tail0", 32'(data_out), 32'h16);
    step(0, 1, 8'h00, "pp.drain1");
    chk("pp.tail1", 32'(data_out), 32'h17);

    // Full with push+pop: popped word is the oldest, occupancy stays full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h20 + i), "fullpp.fill");
    step(1, 1, 8'h99, "fullpp.both");
    chk("fullpp.data", 32'(data_out), 32'h20);
    chk("fullpp.full", 32'(full), 32'h1);
    chk("fullpp.err",  32'(error), 32'h0);

    // Empty with push+pop: no fall-through, error set, word retained.
    do_reset();
    step(1, 1, 8'h55, "emptypp.both");
    chk("emptypp.valid", 32'(valid_out), 32'h0);
    chk("emptypp.err",   32'(error),     32'h1);
    chk("emptypp.empty", 32'(empty),     32'h0);
    step(0, 1, 8'h00, "emptypp.next");
    chk("emptypp.data",  32'(data_out),  32'h55);
    chk("emptypp.vnext", 32'(valid_out), 32'h1);

    // Asynchronous reset between edges with three entries resident.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i), "areset.fill");
    step(0, 1, 8'h00, "areset.pop");
    step(1, 0, 8'h33, "areset.refill");
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_reset_values("areset.mid");
    #1;
    reset_L = 1'b1;
    step(0, 1, 8'h00, "areset.pop_after");
    chk("areset.err",   32'(error),     32'h1);
    chk("areset.valid", 32'(valid_out), 32'h0);
    step(1, 0, 8'h44, "areset.push_after");
    chk("areset.empty", 32'(empty), 32'h0);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit p, q;
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      if (i >= 200 && i < 260) q = ($urandom_range(0, 99) < 10);
      step(p, q, 8'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
